imgproc_mode_scheduler: RTL

//   Sequences the eee_imgproc processing mode frame-by-frame and harvests its 64-bit

---
 rtl/imgproc_mode_scheduler.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/imgproc_mode_scheduler.sv
// -----------------------------------------------------------------------------
// imgproc_mode_scheduler
//
// Purpose:
//   Sequences the eee_imgproc processing mode frame by frame and harvests its
//   64-bit result word. The block drives the mode conduit and watches the
//   Avalon-ST frame boundaries (sop into, eop out of eee_imgproc). It captures
//   the result buffer one cycle after each end-of-frame and queues the captured
//   words, tagged with the mode that produced them, in a small
//   first-word-fall-through FIFO that the Nios/UART reporting path drains.
//
// Parameters:
//   FRAMES_PER_MODE  frames spent in each mode before toggling (>= 1)
//   SETTLE_FRAMES    frames discarded after every mode switch (< FRAMES_PER_MODE)
//   FIFO_DEPTH       result FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES   max cycles between sop and eop before the frame is abandoned
//
// Ports:
//   clk          system clock
//   reset        synchronous reset, active-high
//   enable       run scheduler; 0 = finish current frame, then idle
//   frame_sop    1-cycle pulse at the start of a frame into eee_imgproc
//   frame_eop    1-cycle pulse at the end of a frame out of eee_imgproc
//   result_in    eee_imgproc result buffer, stable from 1 cycle after eop
//   mode_out     mode conduit to eee_imgproc
//   res_valid    FIFO head valid
//   res_data     FIFO head result word
//   res_mode     mode in force when res_data was produced
//   res_ready    consumer accepts the head when res_valid & res_ready
//   drop_cnt     results lost to a full FIFO, saturates at 255
//   timeout_cnt  frames abandoned by the watchdog, saturates at 255
//   busy         1 while the sequencer is not idle
// -----------------------------------------------------------------------------
module imgproc_mode_scheduler #(
  parameter int unsigned FRAMES_PER_MODE = 4,
  parameter int unsigned SETTLE_FRAMES   = 1,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 2**22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_sop,
  input  logic        frame_eop,
  input  logic [63:0] result_in,
  output logic        mode_out,
  output logic        res_valid,
  output logic [63:0] res_data,
  output logic        res_mode,
  input  logic        res_ready,
  output logic [7:0]  drop_cnt,
  output logic [7:0]  timeout_cnt,
  output logic        busy
);

  localparam int unsigned FC_W = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
  localparam int unsigned ST_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;

  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAMES_PER_MODE - 1);
  localparam logic [ST_W-1:0] ST_INIT  = ST_W'(SETTLE_FRAMES);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOP,
    S_IN_FRAME,
    S_CAPTURE
  } state_e;

  // Sequencer state
  state_e          state_q,       state_d;
  logic            mode_q,        mode_d;
  logic [FC_W-1:0] frame_cnt_q,   frame_cnt_d;
  logic [ST_W-1:0] settle_cnt_q,  settle_cnt_d;
  logic [WD_W-1:0] wdog_q,        wdog_d;
  logic [7:0]      timeout_cnt_q, timeout_cnt_d;
  logic            busy_q,        busy_d;

  // Result FIFO: each entry is {mode, result word}
  logic [64:0]     mem_q [FIFO_DEPTH];
  logic [64:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q,      wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,      rd_ptr_d;
  logic [CW-1:0]   count_q,       count_d;
  logic [7:0]      drop_cnt_q,    drop_cnt_d;
  logic            res_valid_q,   res_valid_d;
  logic [63:0]     res_data_q,    res_data_d;
  logic            res_mode_q,    res_mode_d;

  logic            capture_push;
  logic            pop;
  logic            full;
  logic            push_ok;
  logic            drop;
  logic [CW-1:0]   count_after_pop;

  // ---------------------------------------------------------------------------
  // Frame sequencer: frame tracking, watchdog, mode and settle bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    frame_cnt_d   = frame_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    wdog_d        = wdog_q;
    timeout_cnt_d = timeout_cnt_q;
    capture_push  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT_SOP;
        end
      end

      S_WAIT_SOP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (frame_sop) begin
          state_d = S_IN_FRAME;
          wdog_d  = '0;
        end
      end

      S_IN_FRAME: begin
        // A frame already started always runs to completion, whatever enable
        // does. A repeated sop means the eop was lost: restart the watchdog on
        // the new frame instead of capturing.
        if (frame_eop) begin
          state_d = S_CAPTURE;
        end else if (frame_sop) begin
          wdog_d = '0;
        end else if (wdog_q == WD_LAST) begin
          state_d = S_WAIT_SOP;
          if (timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      S_CAPTURE: begin
        if (settle_cnt_q == '0) begin
          capture_push = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q - ST_W'(1);
        end
        // Mode only ever flips here, between frames. The captured word was
        // produced under the old mode, so it is tagged with mode_q.
        if (frame_cnt_q == FC_LAST) begin
          frame_cnt_d  = '0;
          mode_d       = ~mode_q;
          settle_cnt_d = ST_INIT;
        end else begin
          frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
        state_d = enable ? S_WAIT_SOP : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Result FIFO with a registered first-word-fall-through head
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    drop_cnt_d      = drop_cnt_q;
    res_data_d      = res_data_q;
    res_mode_d      = res_mode_q;

    pop             = res_valid_q & res_ready;
    full            = (count_q == CNT_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok         = capture_push & (~full | pop);
    drop            = capture_push & full & ~pop;
    count_after_pop = count_q - CW'(pop);

    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = {mode_q, result_in};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    count_d     = count_after_pop + CW'(push_ok);
    res_valid_d = (count_d != '0);

    // The head register is loaded with whatever entry will sit at the read
    // pointer next cycle. When the word being pushed becomes the head it has
    // not reached mem_q yet, so it is taken straight from the input. With the
    // FIFO empty the head keeps its last value.
    if (count_d != '0) begin
      if (push_ok && (count_after_pop == '0)) begin
        res_mode_d = mode_q;
        res_data_d = result_in;
      end else begin
        res_mode_d = mem_q[rd_ptr_d][64];
        res_data_d = mem_q[rd_ptr_d][63:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      frame_cnt_q   <= '0;
      // Mode 0 counts as freshly entered after reset, so the first frames
      // after reset are discarded just like after any later mode switch.
      settle_cnt_q  <= ST_INIT;
      wdog_q        <= '0;
      timeout_cnt_q <= '0;
      busy_q        <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      drop_cnt_q    <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_mode_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      frame_cnt_q   <= frame_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      wdog_q        <= wdog_d;
      timeout_cnt_q <= timeout_cnt_d;
      busy_q        <= busy_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      drop_cnt_q    <= drop_cnt_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_mode_q    <= res_mode_d;
    end
  end

  assign mode_out    = mode_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_mode    = res_mode_q;
  assign drop_cnt    = drop_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
  assign busy        = busy_q;

endmodule
